// File: rtl/display_pkg.sv
// Shared constants and state encoding for the text-console VRAM write controller.
package display_pkg;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_DEL   = 8'h7F;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLR_SCREEN = 2'd1,
      CLR_LINE   = 2'd2
   } console_state_t;

endpackage

// File: rtl/display_fill.sv
// Sequential address generator for screen and line clears: loads base/count on
// start, then emits one address per cycle until the count is exhausted.
module display_fill (
   input  logic        clk,
   input  logic        start,
   input  logic [11:0] base,
   input  logic [12:0] count,
   output logic [11:0] addr,
   output logic        we,
   output logic        done
);

   logic [11:0] ptr;
   logic [12:0] remaining;

   // start has priority so a restart (reset, FF) always begins from base
   always_ff @(posedge clk) begin
      if (start) begin
         ptr       <= base;
         remaining <= count;
      end else if (remaining != 13'd0) begin
         ptr       <= ptr + 12'd1;
         remaining <= remaining - 13'd1;
      end
   end

   assign addr = ptr;
   assign we   = (remaining != 13'd0);
   assign done = (remaining == 13'd1);

endmodule

// File: rtl/display_console.sv
// Terminal-style VRAM write controller: interprets a byte stream, tracks the
// cursor and row base, and sequences screen/line clears into the VRAM port.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_ready depends on the state alone; in_data/attr must be stable while in_valid.
module display_console
   import display_pkg::*;
#(
   parameter int COLS = 40,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic [7:0]  attr,
   output logic [11:0] waddr,
   output logic [15:0] wdata,
   output logic        we,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   if (COLS * ROWS > 4096) begin : g_size_check
      $error("display_console: COLS*ROWS must not exceed 4096");
   end

   localparam logic [12:0] SCREEN   = 13'(COLS * ROWS);
   localparam logic [12:0] COLS_CNT = 13'(COLS);
   localparam logic [11:0] COLS_W   = 12'(COLS);
   localparam logic [6:0]  X_LAST   = 7'(COLS - 1);
   localparam logic [4:0]  Y_LAST   = 5'(ROWS - 1);

   console_state_t state;
   logic [11:0]    rowbase;

   logic        accept;
   logic        is_print;
   logic        do_nl;
   logic        do_ff;
   logic [11:0] rowbase_nl;
   logic        fill_start;
   logic [11:0] fill_base;
   logic [12:0] fill_count;
   logic [11:0] fill_addr;
   logic        fill_we;
   logic        fill_done;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   // Newline decisions are made combinationally so the fill unit can be armed
   // on the same edge that accepts the byte.
   always_comb begin
      accept     = in_valid && in_ready;
      is_print   = accept && (in_data >= CH_SPACE) && (in_data < CH_DEL);
      do_nl      = accept && ((in_data == CH_LF) || (is_print && cursor_x == X_LAST));
      do_ff      = accept && (in_data == CH_FF);
      rowbase_nl = (cursor_y == Y_LAST) ? 12'd0 : rowbase + COLS_W;
      fill_start = reset || do_ff || do_nl;
      fill_base  = 12'd0;
      fill_count = SCREEN;
      if (!reset && do_nl) begin
         fill_base  = rowbase_nl;
         fill_count = COLS_CNT;
      end
   end

   display_fill u_fill (
      .clk   (clk),
      .start (fill_start),
      .base  (fill_base),
      .count (fill_count),
      .addr  (fill_addr),
      .we    (fill_we),
      .done  (fill_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CLR_SCREEN;
         cursor_x <= 7'd0;
         cursor_y <= 5'd0;
         rowbase  <= 12'd0;
         we       <= 1'b0;
         waddr    <= 12'd0;
         wdata    <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               we <= 1'b0;
               if (is_print) begin
                  we       <= 1'b1;
                  waddr    <= rowbase + {5'd0, cursor_x};
                  wdata    <= {attr, in_data};
                  cursor_x <= (cursor_x == X_LAST) ? 7'd0 : cursor_x + 7'd1;
               end else if (accept) begin
                  case (in_data)
                     CH_LF: cursor_x <= 7'd0;
                     CH_CR: cursor_x <= 7'd0;
                     CH_BS: if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                     CH_FF: begin
                        cursor_x <= 7'd0;
                        cursor_y <= 5'd0;
                        rowbase  <= 12'd0;
                        state    <= CLR_SCREEN;
                     end
                     default: ;
                  endcase
               end
               if (do_nl) begin
                  cursor_y <= (cursor_y == Y_LAST) ? 5'd0 : cursor_y + 5'd1;
                  rowbase  <= rowbase_nl;
                  state    <= CLR_LINE;
               end
            end
            CLR_SCREEN, CLR_LINE: begin
               we    <= fill_we;
               waddr <= fill_addr;
               wdata <= {attr, CH_SPACE};
               if (fill_done) state <= IDLE;
            end
            default: begin
               we    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_console.sv
// Randomized bench for display_console: a cursor/screen reference model queues
// expected VRAM writes, and a negedge monitor pops and compares every write.
module tb_display_console;
   import display_pkg::*;

   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int SCREEN = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic [7:0]  attr = 8'h07;
   logic [11:0] waddr;
   logic [15:0] wdata;
   logic        we;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;
   int mx = 0;
   int my = 0;
   logic [27:0] exp_q[$];
   logic [27:0] mon_e;

   display_console #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .attr      (attr),
      .waddr     (waddr),
      .wdata     (wdata),
      .we        (we),
      .cursor_x  (cursor_x),
      .cursor_y  (cursor_y),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!reset && we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", waddr, wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if ({waddr, wdata} !== mon_e) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        waddr, wdata, mon_e[27:16], mon_e[15:0]);
            end
         end
      end
   end

   // ---------------- reference model helpers ----------------
   task automatic push_clear(input int base, input int n, input logic [7:0] a);
      for (int i = 0; i < n; i++) exp_q.push_back({12'(base + i), a, CH_SPACE});
   endtask

   task automatic newline(input logic [7:0] a, output int len);
      my = (my + 1) % ROWS;
      push_clear(my * COLS, COLS, a);
      len = COLS;
   endtask

   task automatic wait_idle(input int exp_len);
      int n = 0;
      while (busy && n < 5000) begin
         n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != exp_len || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_len: got %0d busy cycles ready=%b, expected %0d ready=1", n, in_ready, exp_len);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      mx = 0;
      my = 0;
      push_clear(0, SCREEN, attr);
      checks++;
      if ({we, waddr, wdata, cursor_x, cursor_y, busy, in_ready} !== {1'b0, 12'd0, 16'd0, 7'd0, 5'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got we=%b addr=%0d data=%h x=%0d y=%0d busy=%b ready=%b, expected 0 0 0000 0 0 1 0",
                  we, waddr, wdata, cursor_x, cursor_y, busy, in_ready);
      end
      wait_idle(SCREEN);
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] a, input bit wait_clr);
      int n = 0;
      int clr = 0;
      logic exp_we = 1'b0;
      while (!in_ready && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL ready_wait: got ready=0 after %0d cycles, expected ready=1", n);
      end
      attr = a;
      in_data = d;
      in_valid = 1'b1;
      if (d >= 8'h20 && d <= 8'h7E) begin
         exp_q.push_back({12'(my * COLS + mx), a, d});
         exp_we = 1'b1;
         mx++;
         if (mx == COLS) begin
            mx = 0;
            newline(a, clr);
         end
      end else if (d == CH_LF) begin
         mx = 0;
         newline(a, clr);
      end else if (d == CH_CR) begin
         mx = 0;
      end else if (d == CH_BS) begin
         if (mx > 0) mx--;
      end else if (d == CH_FF) begin
         mx = 0;
         my = 0;
         push_clear(0, SCREEN, a);
         clr = SCREEN;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if ({we, in_ready, cursor_x, cursor_y} !== {exp_we, (clr == 0), 7'(mx), 5'(my)}) begin
         errors++;
         $display("FAIL post_accept d=%h: got we=%b ready=%b x=%0d y=%0d, expected we=%b ready=%b x=%0d y=%0d",
                  d, we, in_ready, cursor_x, cursor_y, exp_we, (clr == 0), mx, my);
      end
      if (clr != 0 && wait_clr) wait_idle(clr);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] rd;
      int n;
      int r;

      repeat (2) @(posedge clk);
      #1;
      attr = 8'h1E;
      do_reset();

      send(8'h41, 8'h71, 1);

      send(CH_CR, 8'h71, 1);
      for (int i = 0; i < COLS; i++) send(8'(8'h30 + (i % 40)), 8'h52, 1);

      while (my != ROWS - 1) send(CH_LF, 8'h34, 1);
      send(CH_LF, 8'h43, 1);

      send(CH_BS, 8'h07, 1);
      send(8'h42, 8'h07, 1);
      send(8'h43, 8'h07, 1);
      send(CH_BS, 8'h07, 1);
      send(CH_CR, 8'h07, 1);
      send(8'h07, 8'h07, 1);
      send(8'h9F, 8'h07, 1);

      for (int i = 0; i < 250; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         r = $urandom_range(0, 199);
         if (r < 140) rd = 8'($urandom_range(8'h20, 8'h7E));
         else if (r < 156) rd = CH_LF;
         else if (r < 166) rd = CH_CR;
         else if (r < 178) rd = CH_BS;
         else if (r < 188) rd = 8'($urandom_range(8'h7F, 8'hFF));
         else if (r < 197) begin
            rd = 8'($urandom_range(0, 31));
            if (rd == CH_BS || rd == CH_LF || rd == CH_CR || rd == CH_FF) rd = 8'h1B;
         end else rd = CH_FF;
         send(rd, 8'($urandom_range(0, 255)), 1);
      end

      send(CH_CR, 8'h07, 1);
      while (my != 3) send(CH_LF, 8'h07, 1);
      for (int i = 0; i < 5; i++) send(8'h58, 8'h07, 1);
      send(CH_FF, 8'h25, 0);
      n = 0;
      while (!(we && waddr == 12'd600) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!(we && waddr == 12'd600)) begin
         errors++;
         $display("FAIL ff_clear_reach: got addr=%0d we=%b, expected addr=600 we=1", waddr, we);
      end
      do_reset();
      send(8'h5A, 8'h61, 1);

      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d writes outstanding, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
